// File: rtl/am2910_stack_file.sv
// rtl/am2910_stack_file.sv - AM2910-style LIFO stack file feeding the next-address mux F input
// Optional AM2910_STACK_ERR_EN adds sticky ovf/unf error flags.
module am2910_stack_file #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 5,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_push,
  output logic [WIDTH-1:0] f_out,
  output logic [PTR_W-1:0] sp_out,
  output logic             full_n,
  output logic             empty
`ifdef AM2910_STACK_ERR_EN
  ,
  output logic             ovf,
  output logic             unf
`endif
);

  localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  always_comb begin
    sp_d   = sp_q;
    wr_en  = 1'b0;
    wr_idx = '0;
    if (clear) begin
      sp_d = '0;
    end else if (push && pop && (sp_q != '0)) begin
      wr_en  = 1'b1;
      wr_idx = sp_q - SP_ONE;
    end else if (push) begin
      wr_en = 1'b1;
      if (sp_q < SP_FULL) begin
        wr_idx = sp_q;
        sp_d   = sp_q + SP_ONE;
      end else begin
        // Full: overwrite the top entry, older entries stay intact.
        wr_idx = SP_FULL - SP_ONE;
      end
    end else if (pop && (sp_q != '0)) begin
      sp_d = sp_q - SP_ONE;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_idx == PTR_W'(i))) begin
        mem_d[i] = d_push;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q <= sp_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Top of stack is mem[sp-1]; an empty stack presents zero to the mux.
  always_comb begin
    f_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == PTR_W'(i + 1)) begin
        f_out = mem_q[i];
      end
    end
  end

  assign sp_out = sp_q;
  assign full_n = (sp_q != SP_FULL);
  assign empty  = (sp_q == '0);

`ifdef AM2910_STACK_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (push && !pop && (sp_q == SP_FULL)) begin
        ovf_d = 1'b1;
      end
      if (pop && !push && (sp_q == '0)) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`endif

endmodule
